// File: rtl/divider.sv
// Iterative signed 32/32 divider: radix-2 non-restoring core on operand magnitudes,
// STEP quotient bits per clock, with a final sign-fixup stage. out = {remainder, quotient}.
module divider #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [63:0] out,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  logic [33:0] rem;
  logic [31:0] quo;
  logic [31:0] dmag;
  logic        sign_n;
  logic        sign_d;
  logic        zero;

  logic [33:0] rem_w;
  logic [31:0] quo_w;
  logic [33:0] shifted;
  logic [31:0] r_mag;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Next-state logic; capture is folded into IDLE so done and re-capture can share an edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (in2 == 32'h0) ? FIXUP : DIVIDE;
        end else begin
          state_next = IDLE;
        end
      end
      DIVIDE: begin
        if (count == 6'(32 - STEP)) begin
          state_next = FIXUP;
        end else begin
          state_next = DIVIDE;
        end
      end
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // STEP non-restoring iterations: subtract while the partial remainder is non-negative, else add.
  always_comb begin
    rem_w   = rem;
    quo_w   = quo;
    shifted = 34'h0;
    for (int i = 0; i < STEP; i++) begin
      shifted = {rem_w[32:0], quo_w[31]};
      if (!rem_w[33]) begin
        rem_w = shifted - {2'b00, dmag};
      end else begin
        rem_w = shifted + {2'b00, dmag};
      end
      quo_w = {quo_w[30:0], ~rem_w[33]};
    end
  end

  // Restore a negative remainder, then apply operand signs; zero divisor keeps |in1| in quo.
  always_comb begin
    r_mag = rem[33] ? (rem[31:0] + dmag) : rem[31:0];
    if (zero) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = sign_n ? (~quo + 32'd1) : quo;
    end else begin
      q_fix = (sign_n ^ sign_d) ? (~quo + 32'd1) : quo;
      r_fix = sign_n ? (~r_mag + 32'd1) : r_mag;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 6'h0;
      rem         <= 34'h0;
      quo         <= 32'h0;
      dmag        <= 32'h0;
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out         <= 64'h0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_n <= in1[31];
            sign_d <= in2[31];
            zero   <= (in2 == 32'h0);
            quo    <= in1[31] ? (~in1 + 32'd1) : in1;
            dmag   <= in2[31] ? (~in2 + 32'd1) : in2;
            rem    <= 34'h0;
            count  <= 6'h0;
            busy   <= 1'b1;
          end
        end
        DIVIDE: begin
          rem   <= rem_w;
          quo   <= quo_w;
          count <= count + 6'(STEP);
        end
        FIXUP: begin
          out         <= {r_fix, q_fix};
          div_by_zero <= zero;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed cases on a STEP=8 instance, then back-to-back
// signed sweeps on STEP=1/8/32 instances checked against a longint reference model.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [63:0] out;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  logic [64:0] exp_q[$];
  logic        sweep_go = 1'b0;
  logic [1:0]  sweep_fin = 2'b00;

  always #5 clk = ~clk;

  divider #(.STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .div_by_zero(div_by_zero)
  );

  // Reference: {div_by_zero, remainder, quotient}; longint avoids the INT_MIN/-1 overflow.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {div_by_zero, out}, 65'h0_DEAD_BEEF_DEAD_BEEF);
      end else begin
        check("result", {div_by_zero, out}, exp_q.pop_front());
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; checks latency, busy and out hold.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [64:0] hand);
    logic [63:0] prev;
    int lat;
    prev = out;
    lat  = (b == 32'h0) ? 2 : 6;
    in1 = a; in2 = b; start = 1'b1;
    exp_q.push_back(hand);
    @(posedge clk); #1;
    start = 1'b0; in1 = $urandom; in2 = $urandom;
    check("busy_after_capture", 65'(busy), 65'd1);
    for (int k = 2; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k < lat) begin
        check("done_low_while_busy", 65'(done), 65'd0);
        check("out_held_while_busy", 65'(out), 65'(prev));
      end else begin
        check("done_edge", 65'({busy, done}), 65'b01);
      end
    end
  endtask

  // Sweep instances for STEP=1 and STEP=32 with start held high.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int S = (g == 0) ? 1 : 32;
    localparam int L = 32 / S + 2;
    logic        st, bz, dn, dz;
    logic [31:0] a, b;
    logic [63:0] o;
    logic [64:0] q[$];

    divider #(.STEP(S)) u_div (
      .clk(clk), .rst_n(rst_n), .start(st), .in1(a), .in2(b),
      .busy(bz), .done(dn), .out(o), .div_by_zero(dz)
    );

    always @(negedge clk) begin
      if (rst_n && dn) begin
        if (q.size() == 0) begin
          check("sweep_unexpected_done", {dz, o}, 65'h0_DEAD_BEEF_DEAD_BEEF);
        end else begin
          check("sweep_result", {dz, o}, q.pop_front());
        end
      end
    end

    initial begin
      st = 1'b0; a = 32'h0; b = 32'h0;
      wait (sweep_go);
      @(posedge clk); #1;
      st = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (i == 0) begin
          a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        end else begin
          a = $urandom;
          case (i % 4)
            0:       b = 32'h0;
            1:       b = 32'(-$urandom_range(1, 50));
            2:       b = $urandom;
            default: b = 32'($urandom_range(1, 50));
          endcase
        end
        q.push_back(model(a, b));
        repeat ((b == 32'h0) ? 2 : L) @(posedge clk);
        #1;
      end
      st = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("sweep_drained", 65'(q.size()), 65'd0);
      sweep_fin[g] = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in1 = 32'h0; in2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, div_by_zero, out}, 67'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7,          {1'b0, 32'd2,         32'd14});
    run_op(32'hFFFF_FF9C, 32'd7,    {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2});
    run_op(32'd100, 32'hFFFF_FFF9,  {1'b0, 32'd2,         32'hFFFF_FFF2});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0,    32'h8000_0000});
    run_op(32'h8000_0000, 32'd1,    {1'b0, 32'h0,         32'h8000_0000});
    run_op(32'd5, 32'd0,            {1'b1, 32'd5,         32'hFFFF_FFFF});
    run_op(32'd6, 32'd3,            {1'b0, 32'd0,         32'd2});
    run_op(32'hFFFF_FFF9, 32'd0,    {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_op(32'd0, 32'd5,            {1'b0, 32'd0,         32'd0});
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFF, 32'd3});

    // A start pulse while busy is ignored.
    in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    exp_q.push_back({1'b0, 32'd2, 32'd14});
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; in1 = 32'd9; in2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_ignores_start", 65'(busy), 65'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_first_op", 65'(done), 65'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle_after_ignored", 65'({busy, done}), 65'b00);
    end

    // Reset mid-operation aborts silently.
    in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_state", {busy, done, div_by_zero, out}, 67'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("no_done_after_abort", 65'(done), 65'd0);
    end
    run_op(32'd9, 32'd3, {1'b0, 32'd0, 32'd3});

    // Back-to-back with start held high on the STEP=8 instance.
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in1 = $urandom;
      in2 = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) in2 = 32'h0;
      exp_q.push_back(model(in1, in2));
      repeat ((in2 == 32'h0) ? 2 : 6) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("main_drained", 65'(exp_q.size()), 65'd0);

    sweep_go = 1'b1;
    for (int t = 0; t < 5000 && sweep_fin != 2'b11; t++) @(posedge clk);
    #1;
    check("sweeps_finished", 65'(sweep_fin), 65'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
